// File: rtl/sat_pkg.sv
// Shared encodings for the clause-evaluation slice: lit values, free-literal
// count codes, clause status and controller FSM states.
package sat_pkg;

    typedef enum logic [1:0] {
        LIT_FREE     = 2'd0,
        LIT_FALSE    = 2'd1,
        LIT_TRUE     = 2'd2,
        LIT_CONFLICT = 2'd3
    } lit_val_t;

    localparam logic [1:0] FLC_NONE = 2'd0;
    localparam logic [1:0] FLC_ONE  = 2'd1;
    localparam logic [1:0] FLC_MANY = 2'd3;

    typedef enum logic [1:0] {
        CS_UNRESOLVED = 2'd0,
        CS_SAT        = 2'd1,
        CS_UNIT       = 2'd2,
        CS_CONFLICT   = 2'd3
    } clause_status_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_DECIDE   = 3'd2,
        ST_IMPLY    = 3'd3,
        ST_CONFLICT = 3'd4
    } ctrl_state_t;

    // The chain never produces 2, but if it does it means "two or more".
    function automatic logic [1:0] flc_norm(input logic [1:0] flc);
        logic [1:0] res;
        if (flc == 2'd2) begin
            res = FLC_MANY;
        end else begin
            res = flc;
        end
        return res;
    endfunction

endpackage

// File: rtl/clause_eval_ctrl_if.sv
// Handshake and lit-row bundle between the BCP controller / lit_cell row and
// one clause evaluation controller.
interface clause_eval_ctrl_if #(
    parameter int CNT_W = 8
);
    import sat_pkg::*;

    logic                 start_i;
    logic                 clr_i;
    logic [1:0]           freelitcnt_i;
    logic                 clausesat_i;
    logic                 imp_ack_i;
    logic                 imp_drv_o;
    logic                 cclause_drv_o;
    logic                 busy_o;
    logic                 done_o;
    clause_status_t       status_o;
    logic [CNT_W-1:0]     imp_cnt_o;

    modport master (
        output start_i, clr_i, freelitcnt_i, clausesat_i, imp_ack_i,
        input  imp_drv_o, cclause_drv_o, busy_o, done_o, status_o, imp_cnt_o
    );

    modport slave (
        input  start_i, clr_i, freelitcnt_i, clausesat_i, imp_ack_i,
        output imp_drv_o, cclause_drv_o, busy_o, done_o, status_o, imp_cnt_o
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; holds at all-ones once reached.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};

    logic [W-1:0] cnt_r;

    // Count register: increments on enable until saturated.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= CNT_ZERO;
        end else if (en && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt_o = cnt_r;

endmodule

// File: rtl/clause_eval_ctrl.sv
// Per-clause evaluation controller: samples the lit_cell chain after a
// broadcast, classifies the clause and drives the implication/conflict strobes.
module clause_eval_ctrl
    import sat_pkg::*;
#(
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    clause_eval_ctrl_if.slave  bus
);

    localparam logic [2:0] SETTLE_LOAD = 3'(SETTLE_CYC - 1);

    ctrl_state_t    state_r;
    ctrl_state_t    state_s;
    logic [2:0]     settle_cnt_r;
    logic [2:0]     settle_cnt_s;
    clause_status_t status_r;
    clause_status_t status_s;
    logic           done_r;
    logic           done_s;
    logic           busy_r;
    logic           imp_drv_r;
    logic           cclause_drv_r;
    logic           cnt_en_s;
    logic [CNT_W-1:0] imp_cnt_s;

    // Next-state, classification and counter-enable decode; abort has priority.
    always_comb begin
        state_s      = state_r;
        settle_cnt_s = settle_cnt_r;
        status_s     = status_r;
        done_s       = 1'b0;
        cnt_en_s     = 1'b0;
        if (bus.clr_i) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        state_s      = ST_SETTLE;
                        settle_cnt_s = SETTLE_LOAD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_r == 3'd0) begin
                        state_s = ST_DECIDE;
                    end else begin
                        settle_cnt_s = settle_cnt_r - 3'd1;
                    end
                end
                ST_DECIDE: begin
                    if (bus.clausesat_i) begin
                        status_s = CS_SAT;
                        done_s   = 1'b1;
                        state_s  = ST_IDLE;
                    end else begin
                        case (flc_norm(bus.freelitcnt_i))
                            FLC_NONE: begin
                                status_s = CS_CONFLICT;
                                done_s   = 1'b1;
                                state_s  = ST_CONFLICT;
                            end
                            FLC_ONE: begin
                                status_s = CS_UNIT;
                                state_s  = ST_IMPLY;
                            end
                            default: begin
                                status_s = CS_UNRESOLVED;
                                done_s   = 1'b1;
                                state_s  = ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_IMPLY: begin
                    if (bus.imp_ack_i) begin
                        done_s   = 1'b1;
                        cnt_en_s = 1'b1;
                        state_s  = ST_IDLE;
                    end else begin
                        state_s = ST_IMPLY;
                    end
                end
                ST_CONFLICT: begin
                    state_s = ST_CONFLICT;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, settle counter and registered outputs derived from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            settle_cnt_r  <= 3'd0;
            status_r      <= CS_UNRESOLVED;
            done_r        <= 1'b0;
            busy_r        <= 1'b0;
            imp_drv_r     <= 1'b0;
            cclause_drv_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            settle_cnt_r  <= settle_cnt_s;
            status_r      <= status_s;
            done_r        <= done_s;
            busy_r        <= (state_s != ST_IDLE);
            imp_drv_r     <= (state_s == ST_IMPLY);
            cclause_drv_r <= (state_s == ST_CONFLICT);
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_imp_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (cnt_en_s),
        .cnt_o (imp_cnt_s)
    );

    assign bus.imp_drv_o     = imp_drv_r;
    assign bus.cclause_drv_o = cclause_drv_r;
    assign bus.busy_o        = busy_r;
    assign bus.done_o        = done_r;
    assign bus.status_o      = status_r;
    assign bus.imp_cnt_o     = imp_cnt_s;

endmodule

// File: tb/tb_clause_eval_ctrl.sv
// Directed self-checking bench for clause_eval_ctrl (SETTLE_CYC=1, CNT_W=2).
module tb_clause_eval_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    clause_eval_ctrl_if #(.CNT_W(2)) bus ();

    clause_eval_ctrl #(
        .SETTLE_CYC (1),
        .CNT_W      (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Non-unit evaluation: start, two settle/decide edges, classification edge.
    task automatic eval_nonunit(input string tag, input logic sat, input logic [1:0] flc,
                                input logic [1:0] exp_st, input logic exp_cc);
        bus.start_i      = 1'b1;
        bus.clausesat_i  = sat;
        bus.freelitcnt_i = flc;
        step();
        bus.start_i = 1'b0;
        chk({tag, "_busy_settle"}, 8'(bus.busy_o), 8'd1);
        step();
        chk({tag, "_done_early"}, 8'(bus.done_o), 8'd0);
        step();
        chk({tag, "_done"}, 8'(bus.done_o), 8'd1);
        chk({tag, "_status"}, 8'(bus.status_o), 8'(exp_st));
        chk({tag, "_imp_drv"}, 8'(bus.imp_drv_o), 8'd0);
        chk({tag, "_cclause"}, 8'(bus.cclause_drv_o), 8'(exp_cc));
        chk({tag, "_busy"}, 8'(bus.busy_o), 8'(exp_cc));
    endtask

    // Unit evaluation up to the first IMPLY cycle.
    task automatic enter_imply(input string tag);
        bus.start_i      = 1'b1;
        bus.clausesat_i  = 1'b0;
        bus.freelitcnt_i = 2'd1;
        step();
        bus.start_i = 1'b0;
        step();
        step();
        chk({tag, "_imp_drv_on"}, 8'(bus.imp_drv_o), 8'd1);
        chk({tag, "_status_unit"}, 8'(bus.status_o), 8'd2);
        chk({tag, "_no_done"}, 8'(bus.done_o), 8'd0);
    endtask

    initial begin
        logic [1:0] exp_cnt;
        int         done_seen;
        checks = 0;
        errors = 0;
        rst              = 1'b0;
        bus.start_i      = 1'b0;
        bus.clr_i        = 1'b0;
        bus.freelitcnt_i = 2'd0;
        bus.clausesat_i  = 1'b0;
        bus.imp_ack_i    = 1'b0;
        step();
        step();
        chk("rst_imp_drv", 8'(bus.imp_drv_o), 8'd0);
        chk("rst_cclause", 8'(bus.cclause_drv_o), 8'd0);
        chk("rst_busy", 8'(bus.busy_o), 8'd0);
        chk("rst_done", 8'(bus.done_o), 8'd0);
        chk("rst_status", 8'(bus.status_o), 8'd0);
        chk("rst_cnt", 8'(bus.imp_cnt_o), 8'd0);
        rst = 1'b1;
        step();

        // Satisfied clause, then done pulse drops while status holds.
        eval_nonunit("sat", 1'b1, 2'd3, 2'd1, 1'b0);
        step();
        chk("sat_done_pulse", 8'(bus.done_o), 8'd0);
        chk("sat_status_hold", 8'(bus.status_o), 8'd1);

        // Count code 2 behaves as "many": unresolved.
        eval_nonunit("flc2", 1'b0, 2'd2, 2'd0, 1'b0);
        step();
        // Satisfied wins over zero free literals.
        eval_nonunit("sat_prio", 1'b1, 2'd0, 2'd1, 1'b0);
        step();

        // Unit clause: imp_drv for exactly four cycles, ack in the fourth.
        enter_imply("unit");
        for (int i = 1; i < 4; i++) begin
            step();
            chk("unit_imp_drv_hold", 8'(bus.imp_drv_o), 8'd1);
        end
        bus.imp_ack_i = 1'b1;
        step();
        bus.imp_ack_i = 1'b0;
        chk("unit_imp_drv_off", 8'(bus.imp_drv_o), 8'd0);
        chk("unit_done", 8'(bus.done_o), 8'd1);
        chk("unit_cnt", 8'(bus.imp_cnt_o), 8'd1);
        chk("unit_busy_off", 8'(bus.busy_o), 8'd0);
        step();
        chk("unit_done_pulse", 8'(bus.done_o), 8'd0);

        // Conflict: strobe held ten cycles until clr.
        eval_nonunit("confl", 1'b0, 2'd0, 2'd3, 1'b1);
        for (int i = 1; i < 10; i++) begin
            step();
            chk("confl_cclause_hold", 8'(bus.cclause_drv_o), 8'd1);
            chk("confl_no_done", 8'(bus.done_o), 8'd0);
        end
        bus.clr_i = 1'b1;
        step();
        bus.clr_i = 1'b0;
        chk("confl_cclause_off", 8'(bus.cclause_drv_o), 8'd0);
        chk("confl_busy_off", 8'(bus.busy_o), 8'd0);
        chk("confl_clr_no_done", 8'(bus.done_o), 8'd0);
        chk("confl_status_hold", 8'(bus.status_o), 8'd3);

        // Unresolved with a second start during SETTLE that must be ignored.
        bus.start_i      = 1'b1;
        bus.clausesat_i  = 1'b0;
        bus.freelitcnt_i = 2'd3;
        step();
        step();
        bus.start_i = 1'b0;
        step();
        chk("unres_done", 8'(bus.done_o), 8'd1);
        chk("unres_status", 8'(bus.status_o), 8'd0);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.done_o === 1'b1) done_seen++;
        end
        chk("unres_single_done", 8'(done_seen), 8'd0);
        chk("unres_idle", 8'(bus.busy_o), 8'd0);

        // clr and ack together in IMPLY: abort wins.
        enter_imply("abort");
        step();
        bus.clr_i     = 1'b1;
        bus.imp_ack_i = 1'b1;
        step();
        bus.clr_i     = 1'b0;
        bus.imp_ack_i = 1'b0;
        chk("abort_no_done", 8'(bus.done_o), 8'd0);
        chk("abort_cnt", 8'(bus.imp_cnt_o), 8'd1);
        chk("abort_busy", 8'(bus.busy_o), 8'd0);
        chk("abort_imp_drv", 8'(bus.imp_drv_o), 8'd0);
        step();
        chk("abort_done_later", 8'(bus.done_o), 8'd0);

        // clr and start together in IDLE: stays idle.
        bus.clr_i   = 1'b1;
        bus.start_i = 1'b1;
        step();
        bus.clr_i   = 1'b0;
        bus.start_i = 1'b0;
        chk("clr_start_busy", 8'(bus.busy_o), 8'd0);
        step();
        step();
        chk("clr_start_no_done", 8'(bus.done_o), 8'd0);

        // Five more implications: counter saturates at 3.
        exp_cnt = 2'd1;
        for (int k = 0; k < 5; k++) begin
            enter_imply("sat_cnt");
            bus.imp_ack_i = 1'b1;
            step();
            bus.imp_ack_i = 1'b0;
            if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
            chk("sat_cnt_done", 8'(bus.done_o), 8'd1);
            chk("sat_cnt_value", 8'(bus.imp_cnt_o), 8'(exp_cnt));
            step();
        end

        // Asynchronous reset in the middle of IMPLY.
        enter_imply("mid_rst");
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_imp_drv", 8'(bus.imp_drv_o), 8'd0);
        chk("mid_rst_cnt", 8'(bus.imp_cnt_o), 8'd0);
        chk("mid_rst_busy", 8'(bus.busy_o), 8'd0);
        chk("mid_rst_status", 8'(bus.status_o), 8'd0);
        step();
        rst = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
